// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - cpu_controller shared types, IR field constants and instruction classifier
package cpu_pkg;

  typedef enum logic [2:0] {
    S_WAIT,
    S_DECODE,
    S_WRITE_IMM,
    S_GET_A,
    S_GET_B,
    S_ALU,
    S_WRITE_REG,
    S_HALT
  } state_t;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  localparam logic [1:0] VSEL_C     = 2'd0;
  localparam logic [1:0] VSEL_PC    = 2'd1;
  localparam logic [1:0] VSEL_IMM8  = 2'd2;
  localparam logic [1:0] VSEL_MDATA = 2'd3;

  // One-hot register-index select; all-zero selects nothing and yields index 0.
  localparam logic [2:0] NSEL_NONE = 3'b000;
  localparam logic [2:0] NSEL_RN   = 3'b001;
  localparam logic [2:0] NSEL_RD   = 3'b010;
  localparam logic [2:0] NSEL_RM   = 3'b100;

  typedef enum logic [2:0] {
    CLS_ILLEGAL,
    CLS_MOV_IMM,
    CLS_MOV_REG,
    CLS_ADD,
    CLS_CMP,
    CLS_AND,
    CLS_MVN
  } inst_class_t;

  function automatic inst_class_t classify(input logic [2:0] opcode, input logic [1:0] op);
    inst_class_t cls;
    cls = CLS_ILLEGAL;
    if (opcode == OPC_MOV) begin
      if (op == OP_MOV_IMM)      cls = CLS_MOV_IMM;
      else if (op == OP_MOV_REG) cls = CLS_MOV_REG;
    end else if (opcode == OPC_ALU) begin
      case (op)
        OP_ADD:  cls = CLS_ADD;
        OP_CMP:  cls = CLS_CMP;
        OP_AND:  cls = CLS_AND;
        default: cls = CLS_MVN;
      endcase
    end
    return cls;
  endfunction

endpackage

// File: rtl/inst_decoder.sv
// rtl/inst_decoder.sv - combinational IR field split, register-index mux and immediate sign extension
module inst_decoder
  import cpu_pkg::*;
(
  input  logic [15:0] ir,
  input  logic [2:0]  nsel,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic [15:0] sximm5,
  output logic [15:0] sximm8,
  output logic [1:0]  shift_fld,
  output logic [1:0]  op,
  output logic [2:0]  opcode
);

  logic [2:0] rn;
  logic [2:0] rd;
  logic [2:0] rm;
  logic [2:0] rnum;

  assign opcode    = ir[15:13];
  assign op        = ir[12:11];
  assign rn        = ir[10:8];
  assign rd        = ir[7:5];
  assign shift_fld = ir[4:3];
  assign rm        = ir[2:0];

  // AND-OR mux keeps the register index at 0 whenever nothing is selected.
  assign rnum = ({3{nsel[0]}} & rn) | ({3{nsel[1]}} & rd) | ({3{nsel[2]}} & rm);

  assign readnum  = rnum;
  assign writenum = rnum;

  assign sximm8 = {{8{ir[7]}}, ir[7:0]};
  assign sximm5 = {{11{ir[4]}}, ir[4:0]};

endmodule

// File: rtl/cpu_controller.sv
// rtl/cpu_controller.sv - instruction register and control FSM for datapath; CPU_CTRL_ILLEGAL_TRAP_EN selects halt-on-illegal
module cpu_controller
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        s,
  input  logic        load,
  input  logic [15:0] in,
  output logic        w,
  output logic        halt,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic [1:0]  vsel,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        write,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [15:0] sximm8,
  output logic [15:0] sximm5
);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] ir;
  logic [2:0]  nsel;
  logic [1:0]  shift_fld;
  logic [1:0]  op;
  logic [2:0]  opcode;
  inst_class_t cls;

  inst_decoder u_dec (
    .ir        (ir),
    .nsel      (nsel),
    .readnum   (readnum),
    .writenum  (writenum),
    .sximm5    (sximm5),
    .sximm8    (sximm8),
    .shift_fld (shift_fld),
    .op        (op),
    .opcode    (opcode)
  );

  assign cls = classify(opcode, op);

  // IR only accepts a new word while idle, so an in-flight instruction is never disturbed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_WAIT;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_WAIT && load) ir <= in;
    end
  end

  always_comb begin
    state_nxt = state;
    nsel      = NSEL_NONE;
    vsel      = VSEL_C;
    loada     = 1'b0;
    loadb     = 1'b0;
    loadc     = 1'b0;
    loads     = 1'b0;
    write     = 1'b0;
    asel      = 1'b0;
    bsel      = 1'b0;
    shift     = 2'b00;
    ALUop     = 2'b00;
    case (state)
      S_WAIT: begin
        if (s) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        case (cls)
          CLS_MOV_IMM:                  state_nxt = S_WRITE_IMM;
          CLS_MOV_REG, CLS_MVN:         state_nxt = S_GET_B;
          CLS_ADD, CLS_CMP, CLS_AND:    state_nxt = S_GET_A;
          default: begin
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
            state_nxt = S_HALT;
`else
            state_nxt = S_WAIT;
`endif
          end
        endcase
      end
      S_GET_A: begin
        nsel      = NSEL_RN;
        loada     = 1'b1;
        state_nxt = S_GET_B;
      end
      S_GET_B: begin
        nsel      = NSEL_RM;
        loadb     = 1'b1;
        state_nxt = S_ALU;
      end
      S_ALU: begin
        shift = shift_fld;
        // MOV reg reuses the adder with A forced to zero.
        if (cls == CLS_MOV_REG) begin
          asel  = 1'b1;
          ALUop = 2'b00;
        end else begin
          ALUop = op;
        end
        if (cls == CLS_CMP) begin
          loads     = 1'b1;
          state_nxt = S_WAIT;
        end else begin
          loadc     = 1'b1;
          state_nxt = S_WRITE_REG;
        end
      end
      S_WRITE_REG: begin
        nsel      = NSEL_RD;
        vsel      = VSEL_C;
        write     = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WRITE_IMM: begin
        nsel      = NSEL_RN;
        vsel      = VSEL_IMM8;
        write     = 1'b1;
        state_nxt = S_WAIT;
      end
      S_HALT: begin
        state_nxt = S_HALT;
      end
      default: begin
        state_nxt = S_WAIT;
      end
    endcase
  end

  assign w = (state == S_WAIT);

`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
  assign halt = (state == S_HALT);
`else
  assign halt = 1'b0;
`endif

endmodule
